mem_responder: RTL and testbench

- Responder end of the datapath request protocol. It accepts instruction reads (iREN), data reads (dREN) and data writes (dWEN), and returns single-cycle ihit/dhit completion pulses.
- It arbitrates both request streams onto one single-port RAM that uses a ready handshake.
- It sits between the request unit (or caches) and main memory.
- A timeout guard covers RAM accesses that never complete.

---
 rtl/cpu_types_pkg.sv | 5 +
 rtl/mem_responder_pkg.sv | 19 +
 rtl/rr_arbiter2.sv | 39 +++
 rtl/mem_responder.sv | 152 +++++++++++++++
 tb/tb_mem_responder.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: machine word types shared across the datapath.
package cpu_types_pkg;
    localparam int WORD_W = 32;
    typedef logic [WORD_W-1:0] word_t;
endpackage

// File: rtl/mem_responder_pkg.sv
// mem_responder_pkg: FSM state, grant encoding and default error word
// for the memory responder and its arbiter.
package mem_responder_pkg;
    import cpu_types_pkg::*;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DATA  = 2'd1,
        INSTR = 2'd2
    } state_t;

    // Which requester owned the last completed access.
    typedef enum logic {
        GNT_INSTR = 1'b0,
        GNT_DATA  = 1'b1
    } grant_t;

    localparam word_t ERR_WORD_DEF = 32'hBAD1BAD1;
endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-requester round-robin grant.
//   clk, n_rst       clock, async active-low reset
//   req_instr_i      instruction side pending
//   req_data_i       data side pending
//   done_i           an access completed with a hit this cycle
//   done_side_i      side that completed (recorded as last grant)
//   gnt_valid_o      some side is requesting
//   gnt_o            side to serve next (combinational)
module rr_arbiter2
    import mem_responder_pkg::*;
(
    input  logic   clk,
    input  logic   n_rst,
    input  logic   req_instr_i,
    input  logic   req_data_i,
    input  logic   done_i,
    input  grant_t done_side_i,
    output logic   gnt_valid_o,
    output grant_t gnt_o
);

    grant_t last_grant_q;

    // Only hits move the pointer; a withdrawn request leaves it alone.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)      last_grant_q <= GNT_INSTR;
        else if (done_i) last_grant_q <= done_side_i;
    end

    always_comb begin
        gnt_valid_o = req_instr_i | req_data_i;
        gnt_o       = GNT_INSTR;
        if (req_instr_i && req_data_i)
            gnt_o = (last_grant_q == GNT_INSTR) ? GNT_DATA : GNT_INSTR;
        else if (req_data_i)
            gnt_o = GNT_DATA;
    end

endmodule

// File: rtl/mem_responder.sv
// mem_responder: responder end of the datapath request protocol.
// Arbitrates instruction reads and data reads/writes onto one single-port
// RAM with a ready handshake; completion is a Mealy hit pulse in the cycle
// ramready arrives. An access that waits TIMEOUT cycles is aborted with
// ERR_WORD and raises the sticky bus_err.
//   iREN/iaddr                 instruction read request (level)
//   dREN/dWEN/daddr/dstore     data request (level, write wins)
//   ihit/iload, dhit/dload     completion pulses and load data
//   ramREN/ramWEN/ramaddr/ramstore/ramload/ramready   RAM port
//   bus_err                    sticky timeout flag
module mem_responder
    import cpu_types_pkg::*;
    import mem_responder_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                TIMEOUT  = 64,
    parameter logic [DATA_W-1:0] ERR_WORD = DATA_W'(ERR_WORD_DEF)
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    output logic              ihit,
    output logic [DATA_W-1:0] iload,
    output logic              dhit,
    output logic [DATA_W-1:0] dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [DATA_W-1:0] ramstore,
    input  logic [DATA_W-1:0] ramload,
    input  logic              ramready,
    output logic              bus_err
);

    localparam int CW = $clog2(TIMEOUT + 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          bus_err_q, bus_err_d;

    logic   d_req;
    logic   expired;
    logic   gnt_valid;
    grant_t gnt;
    logic   done;
    grant_t done_side;

    assign d_req   = dREN | dWEN;
    assign expired = (cnt_q == CW'(TIMEOUT - 1));
    assign bus_err = bus_err_q;

    rr_arbiter2 u_arb (
        .clk         (clk),
        .n_rst       (n_rst),
        .req_instr_i (iREN),
        .req_data_i  (d_req),
        .done_i      (done),
        .done_side_i (done_side),
        .gnt_valid_o (gnt_valid),
        .gnt_o       (gnt)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bus_err_q <= bus_err_d;
        end
    end

    // All outputs decode from state_q, so an async reset drops the strobes
    // and hits immediately without extra gating.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bus_err_d = bus_err_q;
        done      = 1'b0;
        done_side = GNT_INSTR;
        ihit      = 1'b0;
        iload     = '0;
        dhit      = 1'b0;
        dload     = '0;
        ramREN    = 1'b0;
        ramWEN    = 1'b0;
        ramaddr   = '0;
        ramstore  = '0;

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (gnt_valid) state_d = (gnt == GNT_DATA) ? DATA : INSTR;
            end

            DATA: begin
                ramaddr  = daddr;
                ramstore = dstore;
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                if (!d_req) begin
                    // Requester withdrew: strobes are already low above.
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (ramready || expired) begin
                    dhit      = 1'b1;
                    dload     = ramready ? (dWEN ? '0 : ramload) : ERR_WORD;
                    bus_err_d = bus_err_q | ~ramready;
                    done      = 1'b1;
                    done_side = GNT_DATA;
                    state_d   = IDLE;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            INSTR: begin
                ramaddr = iaddr;
                ramREN  = iREN;
                if (!iREN) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (ramready || expired) begin
                    ihit      = 1'b1;
                    iload     = ramready ? ramload : ERR_WORD;
                    bus_err_d = bus_err_q | ~ramready;
                    done      = 1'b1;
                    done_side = GNT_INSTR;
                    state_d   = IDLE;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed scenarios plus a randomized phase checked
// against a word-array memory model and request-level fairness rules.
module tb_mem_responder;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 64;

    logic          clk = 1'b0;
    logic          n_rst;
    logic          iREN, dREN, dWEN, ramready;
    logic [AW-1:0] iaddr, daddr, ramaddr;
    logic [DW-1:0] dstore, iload, dload, ramstore, ramload;
    logic          ihit, dhit, ramREN, ramWEN, bus_err;

    always #5 clk = ~clk;

    mem_responder #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk      (clk),
        .n_rst    (n_rst),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .daddr    (daddr),
        .dstore   (dstore),
        .ihit     (ihit),
        .iload    (iload),
        .dhit     (dhit),
        .dload    (dload),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload),
        .ramready (ramready),
        .bus_err  (bus_err)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    endtask

    task automatic idle_inputs();
        iREN = 0; dREN = 0; dWEN = 0; ramready = 0;
        iaddr = '0; daddr = '0; dstore = '0; ramload = '0;
    endtask

    // Leaves the bench at posedge+1 of the first post-reset cycle.
    task automatic do_reset();
        n_rst = 0;
        idle_inputs();
        @(posedge clk);
        @(posedge clk);
        #1 n_rst = 1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // random-phase state
    logic [DW-1:0] ram_arr [16];
    logic [DW-1:0] ref_arr [16];
    logic          i_pend, d_pend, d_wr, d_rd, i_done, d_done;
    logic [3:0]    ia, da;
    logic [DW-1:0] ds;
    int            i_other, d_other, nhits;

    initial begin
        int dcyc, icyc, dn, in_, both, kfound;

        // ---- reset: every output quiet even with requests and ready asserted
        n_rst = 0;
        idle_inputs();
        iREN = 1; dREN = 1; dWEN = 1; daddr = 32'h40; iaddr = 32'h80;
        dstore = 32'h1111_2222; ramready = 1; ramload = 32'h3333_4444;
        #3;
        chk("rst_strobe", {ramREN, ramWEN}, 0);
        chk("rst_addr",   ramaddr, 0);
        chk("rst_store",  ramstore, 0);
        chk("rst_hit",    {ihit, dhit}, 0);
        chk("rst_load",   {iload, dload}, 0);
        chk("rst_err",    bus_err, 0);
        do_reset();

        // ---- minimum-latency data read
        dREN = 1; daddr = 32'h40; ramready = 1; ramload = 32'h1234_5678;
        @(negedge clk);
        chk("t1_idle", {ramREN, dhit}, 0);
        tick();
        @(negedge clk);
        chk("t1_ren",   ramREN, 1);
        chk("t1_addr",  ramaddr, 32'h40);
        chk("t1_dhit",  dhit, 1);
        chk("t1_dload", dload, 32'h1234_5678);
        chk("t1_ihit",  ihit, 0);
        tick();
        idle_inputs();
        @(negedge clk);
        chk("t1_after", dhit, 0);

        // ---- both sides from reset: data first, then instruction
        do_reset();
        iREN = 1; dREN = 1; iaddr = 32'h100; daddr = 32'h200;
        ramready = 1; ramload = 32'hCAFE_0000;
        dcyc = -1; icyc = -1; dn = 0; in_ = 0; both = 0;
        for (int c = 0; c < 8; c++) begin
            logic hi, hd;
            @(negedge clk);
            hi = ihit; hd = dhit;
            if (hi && hd) both++;
            if (hd) begin dn++; if (dcyc < 0) dcyc = c; end
            if (hi) begin in_++; if (icyc < 0) icyc = c; end
            tick();
            if (hd) dREN = 0;
            if (hi) iREN = 0;
        end
        chk("t2_dcyc", dcyc, 1);
        chk("t2_icyc", icyc, 3);
        chk("t2_dcnt", dn, 1);
        chk("t2_icnt", in_, 1);
        chk("t2_excl", both, 0);
        idle_inputs();

        // ---- write with read also set, ready on third access cycle
        dWEN = 1; dREN = 1; daddr = 32'h80; dstore = 32'hDEAD_BEEF;
        ramload = 32'h5555_AAAA;
        @(negedge clk);
        chk("t3_idle", ramWEN, 0);
        for (int k = 1; k <= 3; k++) begin
            tick();
            ramready = (k == 3);
            @(negedge clk);
            chk("t3_wen",   ramWEN, 1);
            chk("t3_ren",   ramREN, 0);
            chk("t3_store", ramstore, 32'hDEAD_BEEF);
            chk("t3_dhit",  dhit, (k == 3));
            chk("t3_dload", dload, 0);
        end
        tick();
        idle_inputs();

        // ---- data read withdrawn after two access cycles
        dREN = 1; daddr = 32'h44;
        @(negedge clk);
        tick();
        @(negedge clk);
        chk("t5_acc1", ramREN, 1);
        tick();
        @(negedge clk);
        chk("t5_acc2", ramREN, 1);
        tick();
        dREN = 0;
        #1;
        chk("t5_drop", ramREN, 0);
        @(negedge clk);
        chk("t5_nohit", dhit, 0);
        tick();
        iREN = 1; iaddr = 32'h10; ramready = 1; ramload = 32'h0BAD_F00D;
        @(negedge clk);
        chk("t5_idle", {ramREN, ihit}, 0);
        tick();
        @(negedge clk);
        chk("t5_ihit",  ihit, 1);
        chk("t5_iload", iload, 32'h0BAD_F00D);
        tick();
        idle_inputs();

        // ---- reset in the middle of an instruction access
        iREN = 1; iaddr = 32'h300;
        @(negedge clk);
        tick();
        @(negedge clk);
        chk("t6_acc", ramREN, 1);
        #2 n_rst = 0;
        ramready = 1;
        #1;
        chk("t6_ren",  ramREN, 0);
        chk("t6_ihit", ihit, 0);
        chk("t6_err",  bus_err, 0);
        idle_inputs();
        @(posedge clk);
        #1 n_rst = 1;

        // ---- randomized traffic against a word-array model
        for (int i = 0; i < 16; i++) begin
            ram_arr[i] = $urandom;
            ref_arr[i] = ram_arr[i];
        end
        i_pend = 0; d_pend = 0; d_wr = 0; d_rd = 0; i_done = 0; d_done = 0;
        ia = 0; da = 0; ds = 0; i_other = 0; d_other = 0; nhits = 0;
        for (int cyc = 0; cyc < 3200; cyc++) begin
            logic issue;
            issue = (cyc < 3000);
            if (i_done) i_pend = 0;
            else if (!i_pend && issue && $urandom_range(0, 2) == 0) begin
                i_pend = 1; ia = 4'($urandom); i_other = 0;
            end
            if (d_done) d_pend = 0;
            else if (!d_pend && issue && $urandom_range(0, 2) == 0) begin
                d_pend = 1; da = 4'($urandom); ds = $urandom; d_other = 0;
                d_wr = $urandom_range(0, 1) != 0;
                d_rd = d_wr ? ($urandom_range(0, 1) != 0) : 1'b1;
            end
            i_done = 0; d_done = 0;
            iREN = i_pend; iaddr = {26'd0, ia, 2'b00};
            dREN = d_pend & d_rd; dWEN = d_pend & d_wr;
            daddr = {26'd0, da, 2'b00}; dstore = ds;
            #1;
            ramready = (ramREN | ramWEN) && ($urandom_range(0, 2) != 0);
            ramload  = (ramREN && ramready) ? ram_arr[ramaddr[5:2]] : $urandom;
            @(negedge clk);
            if (ihit || dhit) chk("r_excl", ihit & dhit, 0);
            if (!ihit) chk("r_iload0", iload, 0);
            if (!dhit) chk("r_dload0", dload, 0);
            if (ihit) begin
                nhits++;
                chk("r_iaddr", ramaddr, {26'd0, ia, 2'b00});
                chk("r_iload", iload, ref_arr[ia]);
                chk("r_irdy",  ramready, 1);
                chk("r_ifair", i_other <= 1, 1);
                i_done = 1;
                if (d_pend) d_other++;
            end
            if (dhit) begin
                nhits++;
                chk("r_daddr", ramaddr, {26'd0, da, 2'b00});
                chk("r_drdy",  ramready, 1);
                chk("r_dfair", d_other <= 1, 1);
                if (d_wr) begin
                    chk("r_wen",   ramWEN, 1);
                    chk("r_wload", dload, 0);
                    ref_arr[da] = ds;
                end else begin
                    chk("r_dload", dload, ref_arr[da]);
                end
                d_done = 1;
                if (i_pend) i_other++;
            end
            if (ramWEN && ramready) ram_arr[ramaddr[5:2]] = ramstore;
            tick();
            if (cyc >= 3000 && !i_pend && !d_pend && !i_done && !d_done) break;
        end
        chk("r_drain", {i_pend & ~i_done, d_pend & ~d_done}, 0);
        chk("r_nhit",  nhits > 100, 1);
        chk("r_berr",  bus_err, 0);
        idle_inputs();
        tick();

        // ---- timeout on a stuck instruction read
        iREN = 1; iaddr = 32'h20;
        @(negedge clk);
        kfound = 0;
        for (int k = 1; k <= 200; k++) begin
            tick();
            @(negedge clk);
            if (ihit) begin
                kfound = k;
                chk("to_iload", iload, 32'hBAD1_BAD1);
                break;
            end
        end
        chk("to_cyc", kfound, TO);
        tick();
        iREN = 0;
        @(negedge clk);
        chk("to_err", bus_err, 1);
        tick();
        dREN = 1; daddr = 32'h8; ramready = 1; ramload = 32'h77;
        @(negedge clk);
        tick();
        @(negedge clk);
        chk("to_dhit",   dhit, 1);
        chk("to_dload",  dload, 32'h77);
        chk("to_sticky", bus_err, 1);
        tick();
        idle_inputs();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
